// File: rtl/calendar_pkg.sv
// Shared definitions for the calendar design.
// Contents: ASCII byte constants used by the command parser, error codes
// reported on err_code, the parser state encoding, the command kind and a
// days-in-month helper shared by the field checker and the calendar counter.
package calendar_pkg;

    // ASCII bytes recognised by the command parser
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_T_UP  = 8'h54;
    localparam logic [7:0] ASCII_T_LO  = 8'h74;
    localparam logic [7:0] ASCII_D_UP  = 8'h44;
    localparam logic [7:0] ASCII_D_LO  = 8'h64;

    // Codes reported on err_code
    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_BAD_CHAR   = 3'd1;
    localparam logic [2:0] ERR_RANGE      = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd3;
    localparam logic [2:0] ERR_BREAK      = 3'd4;
    localparam logic [2:0] ERR_OVERLENGTH = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RECV     = 3'd1,
        ST_WAIT_EOL = 3'd2,
        ST_VALIDATE = 3'd3,
        ST_EMIT     = 3'd4,
        ST_DISCARD  = 3'd5
    } parser_state_e;

    typedef enum logic {
        CMD_TIME = 1'b0,
        CMD_DATE = 1'b1
    } cmd_e;

    // Days in a month of year 20yy. Year 00 counts as leap (2000).
    // Months outside 1..12 return 31; callers range-check the month separately.
    function automatic logic [4:0] days_in_month(input logic [6:0] month,
                                                 input logic [6:0] yy);
        case (month)
            7'd4, 7'd6, 7'd9, 7'd11: return 5'd30;
            7'd2:                    return ((yy % 7'd4) == 7'd0) ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/cal_field_check.sv
// Combinational range check of a parsed time or date.
// Ports:
//   cmd      - CMD_TIME: f0=hour, f1=minute, f2=second
//              CMD_DATE: f0=day,  f1=month,  f2=year (20yy)
//   f0/f1/f2 - binary field values, 0..99
//   range_ok - 1 when every field is legal, including day against the
//              month length and leap year
module cal_field_check
    import calendar_pkg::*;
(
    input  cmd_e       cmd,
    input  logic [6:0] f0,
    input  logic [6:0] f1,
    input  logic [6:0] f2,
    output logic       range_ok
);

    logic [4:0] dim;

    always_comb begin
        dim = days_in_month(f1, f2);
        if (cmd == CMD_TIME) begin
            range_ok = (f0 <= 7'd23) && (f1 <= 7'd59) && (f2 <= 7'd59);
        end else begin
            range_ok = (f1 >= 7'd1) && (f1 <= 7'd12) &&
                       (f0 >= 7'd1) && (f0 <= {2'b00, dim});
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII set-time / set-date command parser fed by the UART receiver.
// Frames: 'T'/'t' "hh:mm:ss" CR|LF   or   'D'/'d' "dd/mm/yy" CR|LF.
// Ports:
//   CLK, reset           - clock; asynchronous active-low reset
//   rx_valid, rx_data    - received byte strobe and byte
//   rx_break             - receiver framing/break level
//   set_time, hour/minute/second - one-cycle load strobe and time value
//   set_date, day/month/year     - one-cycle load strobe and date value
//   err, err_code        - one-cycle error strobe; code holds the last error
//   busy                 - parser is not idle
// Handshake: rx_valid has no ready. A byte is consumed in the single cycle
// rx_valid is high; bytes arriving in VALIDATE or EMIT, or alongside a
// break, are dropped. Outputs are registered; a terminator sampled at cycle
// N gives VALIDATE at N+1 and the strobe plus new field values at N+2.
module uart_cmd_parser
    import calendar_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_break,
    output logic       set_time,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       set_date,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic       err,
    output logic [2:0] err_code,
    output logic       busy
);

    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TCW-1:0] TLIM = TCW'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    parser_state_e  state, state_d;
    cmd_e           cmd, cmd_d;
    logic [2:0]     pos, pos_d;
    logic [3:0]     tens, tens_d;
    logic [6:0]     f0, f1, f2, f0_d, f1_d, f2_d;
    logic [TCW-1:0] tcnt, tcnt_d, tcnt_inc;

    logic       set_time_d, set_date_d, err_d;
    logic [2:0] err_code_d;
    logic [4:0] hour_d, day_d;
    logic [5:0] minute_d, second_d;
    logic [3:0] month_d;
    logic [6:0] year_d;

    logic       is_digit, is_eol, is_t_cmd, is_d_cmd, is_sep_pos, char_ok;
    logic       timed_out, range_ok;
    logic [7:0] sep_char;
    logic [6:0] field_val;

    assign is_digit   = (rx_data >= ASCII_ZERO) && (rx_data <= ASCII_NINE);
    assign is_eol     = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
    assign is_t_cmd   = (rx_data == ASCII_T_UP) || (rx_data == ASCII_T_LO);
    assign is_d_cmd   = (rx_data == ASCII_D_UP) || (rx_data == ASCII_D_LO);
    assign sep_char   = (cmd == CMD_DATE) ? ASCII_SLASH : ASCII_COLON;
    assign is_sep_pos = (pos == 3'd2) || (pos == 3'd5);
    assign char_ok    = is_sep_pos ? (rx_data == sep_char) : is_digit;
    // Low nibble of an ASCII digit is its value.
    assign field_val  = 7'(tens) * 7'd10 + 7'(rx_data[3:0]);

    // Fires on the cycle the idle count would reach TIMEOUT_CYCLES.
    assign tcnt_inc  = tcnt + TCW'(1);
    assign timed_out = TIMEOUT_EN && (tcnt_inc == TLIM);

    assign busy = (state != ST_IDLE);

    cal_field_check u_check (
        .cmd      (cmd),
        .f0       (f0),
        .f1       (f1),
        .f2       (f2),
        .range_ok (range_ok)
    );

    always_comb begin
        state_d    = state;
        cmd_d      = cmd;
        pos_d      = pos;
        tens_d     = tens;
        f0_d       = f0;
        f1_d       = f1;
        f2_d       = f2;
        tcnt_d     = '0;
        set_time_d = 1'b0;
        set_date_d = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code;
        hour_d     = hour;
        minute_d   = minute;
        second_d   = second;
        day_d      = day;
        month_d    = month;
        year_d     = year;

        case (state)
            ST_IDLE: begin
                if (rx_valid && (is_t_cmd || is_d_cmd)) begin
                    state_d = ST_RECV;
                    pos_d   = 3'd0;
                    cmd_d   = is_d_cmd ? CMD_DATE : CMD_TIME;
                end
            end

            ST_RECV: begin
                tcnt_d = TIMEOUT_EN ? tcnt_inc : '0;
                if (rx_break) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_BREAK;
                    state_d    = ST_IDLE;
                    tcnt_d     = '0;
                end else if (rx_valid) begin
                    tcnt_d = '0;
                    if (!char_ok) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_CHAR;
                        state_d    = ST_DISCARD;
                    end else begin
                        case (pos)
                            3'd0, 3'd3, 3'd6: tens_d = rx_data[3:0];
                            3'd1:             f0_d   = field_val;
                            3'd4:             f1_d   = field_val;
                            3'd7:             f2_d   = field_val;
                            default:          ;
                        endcase
                        if (pos == 3'd7) state_d = ST_WAIT_EOL;
                        else             pos_d   = pos + 3'd1;
                    end
                end else if (timed_out) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_IDLE;
                    tcnt_d     = '0;
                end
            end

            ST_WAIT_EOL: begin
                tcnt_d = TIMEOUT_EN ? tcnt_inc : '0;
                if (rx_break) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_BREAK;
                    state_d    = ST_IDLE;
                    tcnt_d     = '0;
                end else if (rx_valid) begin
                    tcnt_d = '0;
                    if (is_eol) begin
                        state_d = ST_VALIDATE;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_OVERLENGTH;
                        state_d    = ST_DISCARD;
                    end
                end else if (timed_out) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_IDLE;
                    tcnt_d     = '0;
                end
            end

            ST_VALIDATE: begin
                if (range_ok) begin
                    // Load here so the new values appear together with the
                    // strobe during EMIT.
                    state_d = ST_EMIT;
                    if (cmd == CMD_TIME) begin
                        set_time_d = 1'b1;
                        hour_d     = f0[4:0];
                        minute_d   = f1[5:0];
                        second_d   = f2[5:0];
                    end else begin
                        set_date_d = 1'b1;
                        day_d      = f0[4:0];
                        month_d    = f1[3:0];
                        year_d     = f2;
                    end
                end else begin
                    err_d      = 1'b1;
                    err_code_d = ERR_RANGE;
                    state_d    = ST_IDLE;
                end
            end

            ST_EMIT: begin
                state_d = ST_IDLE;
            end

            ST_DISCARD: begin
                // Silent recovery: no error is raised from here.
                tcnt_d = TIMEOUT_EN ? tcnt_inc : '0;
                if (rx_break) begin
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                end else if (rx_valid) begin
                    tcnt_d = '0;
                    if (is_eol) state_d = ST_IDLE;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cmd      <= CMD_TIME;
            pos      <= 3'd0;
            tens     <= 4'd0;
            f0       <= 7'd0;
            f1       <= 7'd0;
            f2       <= 7'd0;
            tcnt     <= '0;
            set_time <= 1'b0;
            set_date <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            hour     <= 5'd0;
            minute   <= 6'd0;
            second   <= 6'd0;
            day      <= 5'd1;
            month    <= 4'd1;
            year     <= 7'd0;
        end else begin
            state    <= state_d;
            cmd      <= cmd_d;
            pos      <= pos_d;
            tens     <= tens_d;
            f0       <= f0_d;
            f1       <= f1_d;
            f2       <= f2_d;
            tcnt     <= tcnt_d;
            set_time <= set_time_d;
            set_date <= set_date_d;
            err      <= err_d;
            err_code <= err_code_d;
            hour     <= hour_d;
            minute   <= minute_d;
            second   <= second_d;
            day      <= day_d;
            month    <= month_d;
            year     <= year_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed steps for latency, error codes, break,
// timeout and reset, then randomized frames checked against a frame-level
// reference model. Events (err / set_time / set_date) are logged by a
// monitor and compared against an expected queue after each frame.
module tb_uart_cmd_parser;

    localparam int TO = 50;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_break = 1'b0;
    logic       set_time, set_date, err, busy;
    logic [4:0] hour, day;
    logic [5:0] minute, second;
    logic [3:0] month;
    logic [6:0] year;
    logic [2:0] err_code;

    uart_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_break (rx_break),
        .set_time (set_time),
        .hour     (hour),
        .minute   (minute),
        .second   (second),
        .set_date (set_date),
        .day      (day),
        .month    (month),
        .year     (year),
        .err      (err),
        .err_code (err_code),
        .busy     (busy)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    logic [16:0] m_time = 17'd0;                 // {hour, minute, second}
    logic [15:0] m_date = {5'd1, 4'd1, 7'd0};    // {day, month, year}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Event word: {kind, a, b, c}; kind 1 time, 2 date, 3 error (a = code)
    function automatic logic [31:0] ev(input int kind, input int a, input int b, input int c);
        return {8'(kind), 8'(a), 8'(b), 8'(c)};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        if (reset) begin
            if (err || set_time || set_date)
                check("one_strobe", 32'(err) + 32'(set_time) + 32'(set_date), 32'd1);
            if (err)      obs_q.push_back(ev(3, int'(err_code), 0, 0));
            if (set_time) obs_q.push_back(ev(1, int'(hour), int'(minute), int'(second)));
            if (set_date) obs_q.push_back(ev(2, int'(day), int'(month), int'(year)));
        end
    end

    task automatic compare_events(input string tag);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_event"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_fields(input string tag);
        check({tag, "_time"}, 32'({hour, minute, second}), 32'(m_time));
        check({tag, "_date"}, 32'({day, month, year}), 32'(m_date));
    endtask

    task automatic expect_event(input logic [31:0] e);
        exp_q.push_back(e);
        if (e[31:24] == 8'd1) m_time = {e[20:16], e[13:8], e[5:0]};
        if (e[31:24] == 8'd2) m_date = {e[20:16], e[11:8], e[6:0]};
    endtask

    // ---------------- reference model ----------------
    // fr[0] command letter, fr[1..8] body, fr[9..n-1] trailing bytes.
    function automatic logic [31:0] model_frame(input logic [7:0] fr[12], input int n);
        bit   is_date;
        int   v[3];
        int   lim;
        int   mdays[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        logic [7:0] c;
        is_date = (fr[0] == 8'h44) || (fr[0] == 8'h64);
        for (int i = 0; i < 8; i++) begin
            c = fr[i + 1];
            if (i == 2 || i == 5) begin
                if (c != (is_date ? 8'h2F : 8'h3A)) return ev(3, 1, 0, 0);
            end else if (c < 8'h30 || c > 8'h39) begin
                return ev(3, 1, 0, 0);
            end
        end
        if (n < 10 || (fr[9] != CH_CR && fr[9] != CH_LF)) return ev(3, 5, 0, 0);
        for (int k = 0; k < 3; k++)
            v[k] = (int'(fr[3*k + 1]) - 48) * 10 + (int'(fr[3*k + 2]) - 48);
        if (!is_date)
            return (v[0] < 24 && v[1] < 60 && v[2] < 60) ? ev(1, v[0], v[1], v[2]) : ev(3, 2, 0, 0);
        if (v[1] < 1 || v[1] > 12) return ev(3, 2, 0, 0);
        lim = mdays[v[1] - 1] + ((v[1] == 2 && v[2] % 4 == 0) ? 1 : 0);
        return (v[0] >= 1 && v[0] <= lim) ? ev(2, v[0], v[1], v[2]) : ev(3, 2, 0, 0);
    endfunction

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge CLK);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] fr[12];
    int         n, p, a, b, c;
    bit         is_date;
    logic [7:0] sep, ch;
    logic [31:0] e;

    initial begin
        // Reset values
        idle(3);
        check("rst_time", 32'({hour, minute, second}), 32'd0);
        check("rst_date", 32'({day, month, year}), 32'({5'd1, 4'd1, 7'd0}));
        check("rst_flags", 32'({err, err_code, busy, set_time, set_date}), 32'd0);
        reset = 1'b1;
        idle(2);

        // Time frame with exact latency
        send_str("T23:59:58");
        check("busy_mid_frame", 32'(busy), 32'd1);
        send_byte(CH_CR);
        check("lat_n1_no_strobe", 32'({set_time, err}), 32'd0);
        idle(1);
        check("lat_n2_strobe", 32'(set_time), 32'd1);
        check("lat_n2_fields", 32'({hour, minute, second}), 32'({5'd23, 6'd59, 6'd58}));
        idle(1);
        check("post_emit", 32'({set_time, busy}), 32'd0);
        expect_event(ev(1, 23, 59, 58));
        idle(2);
        compare_events("time_ok");

        // Leap day accepted, non-leap rejected
        send_str("D29/02/24"); send_byte(CH_LF); idle(3);
        expect_event(ev(2, 29, 2, 24));
        send_str("D29/02/23"); send_byte(CH_LF); idle(3);
        expect_event(ev(3, 2, 0, 0));
        compare_events("leap");
        check("leap_code", 32'(err_code), 32'd2);
        check_fields("leap");

        // Bad char, discard, then a lowercase command
        send_str("T12:3");
        send_byte(8'h61);
        check("bad_char_err", 32'({err, err_code}), 32'({1'b1, 3'd1}));
        send_str(":00"); send_byte(CH_CR); idle(3);
        check("discard_done", 32'(busy), 32'd0);
        send_str("t01:02:03"); send_byte(CH_LF); idle(3);
        expect_event(ev(3, 1, 0, 0));
        expect_event(ev(1, 1, 2, 3));
        compare_events("bad_char");
        check_fields("bad_char");

        // Overlength, then 31 April
        send_str("D31/12/99");
        send_byte(8'h31);
        check("overlen_err", 32'({err, err_code}), 32'({1'b1, 3'd5}));
        send_byte(CH_CR); idle(3);
        send_str("D31/04/10"); send_byte(CH_CR); idle(3);
        expect_event(ev(3, 5, 0, 0));
        expect_event(ev(3, 2, 0, 0));
        compare_events("overlen");
        check_fields("overlen");

        // Timeout exactly TO cycles after the last accepted byte
        send_str("T12:");
        idle(TO - 1);
        check("timeout_early", 32'({err, busy}), 32'({1'b0, 1'b1}));
        idle(1);
        check("timeout_fire", 32'({err, err_code, busy}), 32'({1'b1, 3'd3, 1'b0}));
        idle(2);
        expect_event(ev(3, 3, 0, 0));
        compare_events("timeout");

        // Break mid-frame
        send_str("D0");
        @(negedge CLK); rx_break = 1'b1;
        @(negedge CLK); rx_break = 1'b0;
        check("break_err", 32'({err, err_code, busy}), 32'({1'b1, 3'd4, 1'b0}));
        idle(2);
        expect_event(ev(3, 4, 0, 0));
        compare_events("break");

        // Break together with a byte: break wins, byte dropped
        send_str("T1");
        @(negedge CLK); rx_break = 1'b1; rx_valid = 1'b1; rx_data = 8'h32;
        @(negedge CLK); rx_break = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        check("break_valid_err", 32'({err, err_code, busy}), 32'({1'b1, 3'd4, 1'b0}));
        send_str("3:00:00"); send_byte(CH_CR); idle(3);
        check("break_valid_idle", 32'(busy), 32'd0);
        expect_event(ev(3, 4, 0, 0));
        compare_events("break_valid");
        check_fields("break_valid");

        // Timeout while discarding is silent
        send_str("T1x");
        idle(TO + 10);
        check("discard_timeout_idle", 32'(busy), 32'd0);
        expect_event(ev(3, 1, 0, 0));
        compare_events("discard_timeout");

        // Reset mid-frame
        send_str("D15/0");
        @(negedge CLK); reset = 1'b0;
        #1;
        check("mid_rst_time", 32'({hour, minute, second}), 32'd0);
        check("mid_rst_date", 32'({day, month, year}), 32'({5'd1, 4'd1, 7'd0}));
        check("mid_rst_flags", 32'({err, err_code, busy, set_time, set_date}), 32'd0);
        idle(2);
        reset = 1'b1;
        m_time = 17'd0;
        m_date = {5'd1, 4'd1, 7'd0};
        idle(3);
        compare_events("mid_reset");

        // Randomized frames
        for (int t = 0; t < 40; t++) begin
            is_date = 1'($urandom_range(0, 1));
            if (is_date) begin
                fr[0] = ($urandom_range(0, 1) == 0) ? 8'h44 : 8'h64;
                a = $urandom_range(0, 33); b = $urandom_range(0, 14); c = $urandom_range(0, 99);
                sep = 8'h2F;
            end else begin
                fr[0] = ($urandom_range(0, 1) == 0) ? 8'h54 : 8'h74;
                a = $urandom_range(0, 27); b = $urandom_range(0, 65); c = $urandom_range(0, 65);
                sep = 8'h3A;
            end
            fr[1] = 8'(48 + a / 10); fr[2] = 8'(48 + a % 10); fr[3] = sep;
            fr[4] = 8'(48 + b / 10); fr[5] = 8'(48 + b % 10); fr[6] = sep;
            fr[7] = 8'(48 + c / 10); fr[8] = 8'(48 + c % 10);
            n = 9;
            if ($urandom_range(0, 4) == 0) begin
                p = $urandom_range(1, 8);
                do ch = 8'($urandom_range(33, 126));
                while ((p == 3 || p == 6) ? (ch == sep) : (ch >= 8'h30 && ch <= 8'h39));
                fr[p] = ch;
            end
            if ($urandom_range(0, 5) == 0) begin
                fr[n] = 8'(48 + $urandom_range(0, 9));
                n++;
            end
            fr[n] = ($urandom_range(0, 1) == 0) ? CH_CR : CH_LF;
            n++;
            if ($urandom_range(0, 3) == 0) send_byte(8'h78);
            e = model_frame(fr, n);
            expect_event(e);
            for (int i = 0; i < n; i++) begin
                send_byte(fr[i]);
                idle($urandom_range(0, 3));
            end
            idle(4);
            compare_events("rand");
            check_fields("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
